// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for pipeline boundary registers.
//   PIPE_PAYLOAD_W : default payload width (ALU result, memory result, dest, control)
//   PIPE_CTRL_W    : default count of low payload bits that act as control enables
//   skid_state_e   : occupancy-coded state of a two-entry skid register
package pipe_pkg;

    localparam int PIPE_PAYLOAD_W = 70;
    localparam int PIPE_CTRL_W    = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register placed at a pipeline boundary (EX/MEM, MEM/WB).
// in_ready depends only on registered state, which breaks the ready path
// between stages while still sustaining one transfer per cycle.
// The main entry drives the output and the skid entry catches one extra
// payload when downstream stalls.
//
// state    | meaning
// ---------+------------------------------------------
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | main entry valid, skid entry free
// ST_FULL  | main and skid valid, in_ready=0
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   flush               : drop all held entries (bubble insertion)
//   in_valid/in_data    : upstream payload, accepted when in_ready=1
//   in_ready            : block can accept (registered state only)
//   out_valid/out_data  : main entry; control bits masked when not valid
//   out_ready           : downstream accepts
//   occupancy           : held entry count 0..2
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
    parameter int CTRL_W    = PIPE_CTRL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy
);

    localparam logic [PAYLOAD_W-1:0] CTRL_MASK =
        {{(PAYLOAD_W-CTRL_W){1'b0}}, {CTRL_W{1'b1}}};

    skid_state_e          state_q, state_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 in_fire;
    logic                 out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Any coincident in_fire is accepted and dropped; any coincident
            // out_fire has already delivered main this cycle.
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state_q)
            ST_EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            ST_ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            ST_FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
        // main keeps stale data after draining; mask control so a bubble
        // never asserts write-back or memory-read downstream.
        out_data = out_valid ? main_q : (main_q & ~CTRL_MASK);
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 70, payload bits per entry (32 ALU result + 32 memory result + 4 dest + 2 control).
REQ-002 SHALL have parameter CTRL_W, default 2, count of low payload bits treated as control enables (WB_EN, MEM_R_EN).
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, discard all held entries (pipeline bubble insertion).
REQ-006 SHALL have port in_valid, input, 1, upstream payload valid.
REQ-007 SHALL have port in_data, input, PAYLOAD_W, upstream payload.
REQ-008 SHALL have port in_ready, output, 1, block can accept; registered, a function of state only.
REQ-009 SHALL have port out_valid, output, 1, main entry holds valid payload.
REQ-010 SHALL have port out_data, output, PAYLOAD_W, main entry payload; control bits forced 0 when out_valid=0.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port occupancy, output, 2, held entry count, 0..2.

Function
REQ-013 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-014 SHALL hold two entries, main and skid, with state EMPTY (0), ONE (main only), FULL (main+skid); occupancy = 0/1/2 respectively.
REQ-015 SHALL drive in_ready=1 in EMPTY and ONE, 0 in FULL.
REQ-016 EMPTY: in_fire -> ONE, main<=in_data; otherwise stay.
REQ-017 ONE: in_fire & out_fire -> ONE, main<=in_data; in_fire & !out_fire -> FULL, skid<=in_data; !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-018 FULL: out_fire -> ONE, main<=skid; otherwise hold; in_valid ignored.
REQ-019 SHALL give latency of exactly 1 cycle from in_fire to out_valid when EMPTY or when ONE with out_fire.
REQ-020 SHALL sustain one transfer per cycle with out_ready held high, no bubbles.
REQ-021 SHALL preserve strict FIFO order; no payload duplicated or lost except via flush.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-023 flush SHALL take priority over all transitions: next state EMPTY, main and skid zeroed, regardless of in_fire/out_fire that cycle.
REQ-024 An in_fire coinciding with flush SHALL be treated as accepted and discarded; an out_fire coinciding with flush SHALL count as delivered.
REQ-025 SHALL force out_data[CTRL_W-1:0]=0 whenever out_valid=0, so a bubble never asserts write-back or memory-read.

Reset
REQ-026 rst=1 at a rising edge SHALL set state EMPTY and zero main and skid, overriding flush and all handshakes.
REQ-027 During and after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1 (first cycle after deassertion).
REQ-028 Reset asserted mid-transfer SHALL discard all held entries with no partial update.

Structure
REQ-029 SHALL place state encoding (EMPTY/ONE/FULL) and default PAYLOAD_W/CTRL_W constants in shared package pipe_pkg.
REQ-030 SHALL be a single module; no sub-module; instantiated per pipeline boundary (EX/MEM, MEM/WB) with field packing done by the instantiating stage.

Verification
REQ-031 Reset: rst=1 2 cycles with in_valid=1, in_data=0x3FF... -> out_valid=0, occupancy=0, in_ready=1 after release.
REQ-032 Streaming: out_ready=1, in_valid=1 for 8 cycles, data 1..8 -> out_data 1..8 on consecutive cycles, each 1 cycle after acceptance, occupancy stays 1.
REQ-033 Backpressure: out_ready=0, send A=0x11, B=0x22 -> occupancy=2, in_ready=0, out_data=0x11 stable; out_ready=1 -> 0x11 then 0x22, in_ready=1 one cycle after first out_fire.
REQ-034 Flush in FULL with in_valid=1 and out_ready=1 -> next cycle out_valid=0, occupancy=0, out_data=0, offered payload never appears.
REQ-035 Bubble control: payload with control bits 2'b11 after out_fire leaves EMPTY -> out_data[1:0]=0 while out_valid=0.
REQ-036 Random valid/ready 10k cycles with scoreboard -> ordered, lossless, no duplicates outside flush windows.
